ret_pred_check: RTL

Return-prediction checker that sits directly downstream of the return address stack. It records each return-address prediction issued at fetch in a small in-order FIFO. When the corresponding JR resolves in execute, it compares the predicted target against the resolved one. On a mismatch or a missing prediction it issues a registered flush/redirect pulse sequence to the front end and keeps hit/miss statistics.

---
 rtl/ret_pred_check_pkg.sv | 21 ++
 rtl/ret_pred_check_pred_fifo.sv | 67 ++++++
 rtl/ret_pred_check.sv | 132 +++++++++++++
 3 files changed

// File: rtl/ret_pred_check_pkg.sv
// Shared types for the return-prediction checker, RAS and fetch stages.
package ret_pred_check_pkg;

  localparam int ADDR_W = 32;

  typedef struct packed {
    logic              predicted;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] pc;
  } pred_entry_t;

  typedef enum logic {
    ST_CHECK = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  function automatic logic pred_hit(pred_entry_t e, logic [ADDR_W-1:0] actual);
    return e.predicted && (e.addr == actual);
  endfunction

endpackage

// File: rtl/ret_pred_check_pred_fifo.sv
// In-order prediction FIFO; single-cycle push/pop, clear wins over push.
// A push is taken while full only if a pop frees the head slot in the same cycle.
module pred_fifo
  import ret_pred_check_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        push_i,
  input  logic        pop_i,
  input  logic        clear_i,
  input  pred_entry_t wdata_i,
  output logic        full_o,
  output logic        empty_o,
  output pred_entry_t head_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  pred_entry_t      mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop_i && !empty_o;
    do_push  = push_i && (!full_o || do_pop);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset: the count alone decides which slots are live.
  always_ff @(posedge clk_i) begin
    if (do_push && !clear_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/ret_pred_check.sv
// Checks RAS return predictions against resolved JR targets; on a miss it
// clears the FIFO, pulses a redirect and holds Flush_OUT for FLUSH_CYCLES.
module ret_pred_check
  import ret_pred_check_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              Pred_push_IN,
  input  logic              Pred_valid_IN,
  input  logic [ADDR_W-1:0] Pred_addr_IN,
  input  logic [ADDR_W-1:0] Pred_pc_IN,
  input  logic              Resolve_IN,
  input  logic [ADDR_W-1:0] Resolved_addr_IN,
  output logic              Full_OUT,
  output logic              Flush_OUT,
  output logic              Redirect_OUT,
  output logic [ADDR_W-1:0] Redirect_addr_OUT,
  output logic [CNT_W-1:0]  Hits_OUT,
  output logic [CNT_W-1:0]  Misses_OUT,
  output logic              Error_OUT
);

  state_e            state_q, state_d;
  logic [2:0]        flush_cnt_q, flush_cnt_d;
  logic              redirect_q, redirect_d;
  logic [ADDR_W-1:0] redirect_addr_q, redirect_addr_d;
  logic [CNT_W-1:0]  hits_q, hits_d;
  logic [CNT_W-1:0]  misses_q, misses_d;
  logic              error_q, error_d;

  logic              fifo_push, fifo_pop, fifo_clear;
  logic              fifo_full, fifo_empty;
  pred_entry_t       wr_entry, head;
  logic              do_pop, head_hit;

  assign wr_entry = '{predicted: Pred_valid_IN, addr: Pred_addr_IN, pc: Pred_pc_IN};

  pred_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_ni  (RESET),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .clear_i (fifo_clear),
    .wdata_i (wr_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (head)
  );

  // The JR PC rides along only for waveform debug of the head entry.
  logic unused_head_pc;
  assign unused_head_pc = ^head.pc;

  assign do_pop   = Resolve_IN && !fifo_empty;
  assign head_hit = pred_hit(head, Resolved_addr_IN);

  always_comb begin
    state_d         = state_q;
    flush_cnt_d     = flush_cnt_q;
    redirect_d      = 1'b0;
    redirect_addr_d = redirect_addr_q;
    hits_d          = hits_q;
    misses_d        = misses_q;
    error_d         = error_q;
    fifo_push       = 1'b0;
    fifo_pop        = 1'b0;
    fifo_clear      = 1'b0;
    case (state_q)
      ST_CHECK: begin
        if (Resolve_IN && fifo_empty) error_d = 1'b1;
        if (Pred_push_IN && fifo_full && !do_pop) error_d = 1'b1;
        if (do_pop) begin
          fifo_pop = 1'b1;
          if (head_hit) begin
            hits_d    = (hits_q == {CNT_W{1'b1}}) ? hits_q : hits_q + 1'b1;
            fifo_push = Pred_push_IN;
          end else begin
            // Everything younger than the mispredicted JR is wrong-path.
            misses_d        = (misses_q == {CNT_W{1'b1}}) ? misses_q : misses_q + 1'b1;
            redirect_d      = 1'b1;
            redirect_addr_d = Resolved_addr_IN;
            fifo_clear      = 1'b1;
            flush_cnt_d     = 3'(FLUSH_CYCLES - 1);
            state_d         = ST_FLUSH;
          end
        end else begin
          fifo_push = Pred_push_IN && !fifo_full;
        end
      end
      ST_FLUSH: begin
        if (flush_cnt_q == 3'd0) state_d = ST_CHECK;
        else                     flush_cnt_d = flush_cnt_q - 3'd1;
      end
      default: state_d = ST_CHECK;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q         <= ST_CHECK;
      flush_cnt_q     <= '0;
      redirect_q      <= 1'b0;
      redirect_addr_q <= '0;
      hits_q          <= '0;
      misses_q        <= '0;
      error_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      flush_cnt_q     <= flush_cnt_d;
      redirect_q      <= redirect_d;
      redirect_addr_q <= redirect_addr_d;
      hits_q          <= hits_d;
      misses_q        <= misses_d;
      error_q         <= error_d;
    end
  end

  assign Full_OUT          = fifo_full;
  assign Flush_OUT         = (state_q == ST_FLUSH);
  assign Redirect_OUT      = redirect_q;
  assign Redirect_addr_OUT = redirect_addr_q;
  assign Hits_OUT          = hits_q;
  assign Misses_OUT        = misses_q;
  assign Error_OUT         = error_q;

endmodule
